// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file defaults and address-width helper.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits with set/clear/flush and a registered popcount.
module reg_scoreboard import rv_pkg::*; #(
  parameter int NREG = NREG_DEF,
  localparam int AW = addr_w(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     pend_cnt
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  // set is applied after clear so an issue and writeback to the same register leaves it pending
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    if (flush) busy_d = '0;
    cnt_d = '0;
    for (int k = 0; k < NREG; k++) cnt_d = cnt_d + (AW+1)'(busy_d[k]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign busy     = busy_q;
  assign pend_cnt = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on read ports.
module regfile_scoreboard import rv_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end
  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .flush    (flush),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_addr[i*AW +: AW];
    assign hit = BYP && wr_en && wr_addr == ra;
    assign rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : hit ? wr_data : regs_q[ra];
    assign rd_busy[i] = (ra != '0) && (hit ? (iss_en && iss_addr == ra) : busy[ra]);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plus random checks against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREG = 32, NRD = 2, AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wr_en = 0, iss_en = 0, flush = 0;
  logic [AW-1:0] wr_addr = '0, iss_addr = '0;
  logic [XLEN-1:0] wr_data = '0;
  logic [AW:0] pend_cnt;
  int checks = 0, errors = 0;
  logic [XLEN-1:0] m_regs [NREG];
  bit m_busy [NREG];

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += m_busy[r];
    return n;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 0;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NRD; p++) begin
      int a = int'(rd_addr[p*AW +: AW]);
      logic [XLEN-1:0] ed;
      logic eb;
      if (a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (BYP && wr_en && int'(wr_addr) == a) begin
        ed = wr_data; eb = iss_en && int'(iss_addr) == a;
      end else begin
        ed = m_regs[a]; eb = m_busy[a];
      end
      chk($sformatf("rd_data%0d[x%0d]", p, a), 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("rd_busy%0d[x%0d]", p, a), 64'(rd_busy[p]), 64'(eb));
    end
    chk("pend_cnt", 64'(pend_cnt), 64'(m_cnt()));
  endtask

  task automatic set_in(input logic we, input int wa, input logic [XLEN-1:0] wd,
                        input logic ie, input int ia, input logic fl, input int r0, input int r1);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia); flush = fl;
    rd_addr = {AW'(r1), AW'(r0)};
  endtask

  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    if (wr_en && wr_addr != '0) m_regs[wr_addr] = wr_data;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    end else begin
      if (wr_en) m_busy[wr_addr] = 0;
      if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1;
    end
    #1;
  endtask

  initial begin
    m_reset();
    @(posedge clk); #1;
    chk("reset_pend", 64'(pend_cnt), 64'd0);
    reset = 1'b0;
    // write x5, read back on both ports next cycle
    set_in(1, 5, 32'hAB, 0, 0, 0, 5, 5); cycle();
    set_in(0, 0, 0, 0, 0, 0, 5, 5); #2;
    chk("x5_p0", 64'(rd_data[31:0]), 64'hAB);
    chk("x5_p1", 64'(rd_data[63:32]), 64'hAB);
    cycle();
    set_in(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("x0_p0", 64'(rd_data[31:0]), 64'h0);
    cycle();
    // two issues, then one writeback
    set_in(0, 0, 0, 1, 3, 0, 3, 7); cycle();
    set_in(0, 0, 0, 1, 7, 0, 3, 7); cycle();
    set_in(0, 0, 0, 0, 0, 0, 3, 7); #2;
    chk("pend2", 64'(pend_cnt), 64'd2);
    chk("busy_x3", 64'(rd_busy[0]), 64'd1);
    cycle();
    set_in(1, 3, 32'h10, 0, 0, 0, 3, 7); cycle();
    set_in(0, 0, 0, 0, 0, 0, 3, 7); #2;
    chk("pend1", 64'(pend_cnt), 64'd1);
    chk("x3_free", 64'(rd_busy[0]), 64'd0);
    chk("x7_busy", 64'(rd_busy[1]), 64'd1);
    chk("x3_data", 64'(rd_data[31:0]), 64'h10);
    cycle();
    // same-cycle issue and writeback: set wins
    set_in(1, 4, 32'h22, 1, 4, 0, 4, 4); cycle();
    set_in(0, 0, 0, 0, 0, 0, 4, 4); #2;
    chk("x4_busy", 64'(rd_busy[0]), 64'd1);
    chk("x4_pend", 64'(pend_cnt), 64'd2);
    chk("x4_data", 64'(rd_data[31:0]), 64'h22);
    cycle();
    // flush beats a simultaneous issue
    set_in(0, 0, 0, 1, 1, 0, 1, 2); cycle();
    set_in(0, 0, 0, 1, 2, 0, 1, 2); cycle();
    set_in(0, 0, 0, 1, 9, 0, 1, 9); cycle();
    set_in(0, 0, 0, 1, 6, 1, 6, 9); cycle();
    set_in(0, 0, 0, 0, 0, 0, 6, 9); #2;
    chk("flush_pend", 64'(pend_cnt), 64'd0);
    chk("flush_b0", 64'(rd_busy[0]), 64'd0);
    chk("flush_b1", 64'(rd_busy[1]), 64'd0);
    cycle();
    // same-cycle write and read of a pending register
    set_in(1, 8, 32'h11, 0, 0, 0, 8, 8); cycle();
    set_in(0, 0, 0, 1, 8, 0, 8, 8); cycle();
    set_in(1, 8, 32'h55, 0, 0, 0, 8, 8); #2;
    chk("byp_data", 64'(rd_data[31:0]), BYP ? 64'h55 : 64'h11);
    chk("byp_busy", 64'(rd_busy[1]), BYP ? 64'd0 : 64'd1);
    cycle();
    set_in(1, 8, 32'h66, 1, 8, 0, 8, 8); #2;
    chk("bypi_data", 64'(rd_data[31:0]), BYP ? 64'h66 : 64'h55);
    chk("bypi_busy", 64'(rd_busy[0]), BYP ? 64'd1 : 64'd0);
    cycle();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(1, 0) == 1, $urandom_range(NREG-1, 0), $urandom,
             $urandom_range(9, 0) < 4, $urandom_range(NREG-1, 0), $urandom_range(19, 0) == 0,
             $urandom_range(NREG-1, 0), $urandom_range(NREG-1, 0));
      cycle();
    end
    // reset mid-run clears outputs before the next edge
    set_in(0, 0, 0, 1, 5, 0, 5, 4); cycle();
    set_in(0, 0, 0, 0, 0, 0, 5, 4);
    #2 reset = 1'b1;
    #1;
    chk("rst_d0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_d1", 64'(rd_data[63:32]), 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    chk("rst_pend", 64'(pend_cnt), 64'h0);
    m_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(1, 5, 32'h77, 1, 5, 0, 5, 4); cycle();
    set_in(0, 0, 0, 0, 0, 0, 5, 4); cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
